// File: rtl/csr_pkg.sv
// csr_pkg: shared definitions for the machine-mode CSR file.
// CSR addresses, wr_op encodings, mstatus layout, MISA value, the decoded
// CSR selector and the small pure helpers used by the write chain and reads.
// Build option: CSR_COUNTERS_EN makes the eight counter addresses decode.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_RW  = 2'b01;
   localparam logic [1:0] OP_RS  = 2'b10;
   localparam logic [1:0] OP_RC  = 2'b11;

   localparam int          MSTATUS_MIE  = 3;
   localparam int          MSTATUS_MPIE = 7;
   localparam logic [31:0] MSTATUS_MASK = (32'd1 << MSTATUS_MIE) | (32'd1 << MSTATUS_MPIE);
   localparam logic [31:0] MEPC_MASK    = 32'hFFFF_FFFC;
   localparam logic [31:0] MISA_VALUE   = 32'h4000_0100;

   typedef enum logic [4:0] {
      SEL_NONE, SEL_MSTATUS, SEL_MISA, SEL_MIE, SEL_MTVEC, SEL_MSCRATCH,
      SEL_MEPC, SEL_MCAUSE, SEL_MTVAL, SEL_MIP,
      SEL_MCYCLE, SEL_MCYCLEH, SEL_MINSTRET, SEL_MINSTRETH,
      SEL_CYCLE, SEL_CYCLEH, SEL_INSTRET, SEL_INSTRETH
   } csr_sel_e;

   // Architectural view of every stored CSR; counters split into halves.
   typedef struct packed {
      logic [31:0] mstatus;
      logic [31:0] mie;
      logic [31:0] mtvec;
      logic [31:0] mscratch;
      logic [31:0] mepc;
      logic [31:0] mcause;
      logic [31:0] mtval;
      logic [31:0] mcycle_lo;
      logic [31:0] mcycle_hi;
      logic [31:0] minstret_lo;
      logic [31:0] minstret_hi;
   } csr_state_t;

   function automatic csr_sel_e csr_decode(input logic [11:0] addr);
      case (addr)
         CSR_MSTATUS:   return SEL_MSTATUS;
         CSR_MISA:      return SEL_MISA;
         CSR_MIE:       return SEL_MIE;
         CSR_MTVEC:     return SEL_MTVEC;
         CSR_MSCRATCH:  return SEL_MSCRATCH;
         CSR_MEPC:      return SEL_MEPC;
         CSR_MCAUSE:    return SEL_MCAUSE;
         CSR_MTVAL:     return SEL_MTVAL;
         CSR_MIP:       return SEL_MIP;
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE:    return SEL_MCYCLE;
         CSR_MCYCLEH:   return SEL_MCYCLEH;
         CSR_MINSTRET:  return SEL_MINSTRET;
         CSR_MINSTRETH: return SEL_MINSTRETH;
         CSR_CYCLE:     return SEL_CYCLE;
         CSR_CYCLEH:    return SEL_CYCLEH;
         CSR_INSTRET:   return SEL_INSTRET;
         CSR_INSTRETH:  return SEL_INSTRETH;
`endif
         default:       return SEL_NONE;
      endcase
   endfunction

   // Read-only and unimplemented selectors reject any real write op.
   function automatic logic csr_writable(input csr_sel_e sel);
      case (sel)
         SEL_NONE, SEL_MISA, SEL_MIP,
         SEL_CYCLE, SEL_CYCLEH, SEL_INSTRET, SEL_INSTRETH: return 1'b0;
         default:                                          return 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] csr_rmw(input logic [31:0] old_v,
                                           input logic [1:0]  op,
                                           input logic [31:0] data);
      case (op)
         OP_RW:   return data;
         OP_RS:   return old_v | data;
         OP_RC:   return old_v & ~data;
         default: return old_v;
      endcase
   endfunction

   function automatic logic [31:0] csr_value(input csr_state_t st, input csr_sel_e sel);
      case (sel)
         SEL_MSTATUS:               return st.mstatus;
         SEL_MISA:                  return MISA_VALUE;
         SEL_MIE:                   return st.mie;
         SEL_MTVEC:                 return st.mtvec;
         SEL_MSCRATCH:              return st.mscratch;
         SEL_MEPC:                  return st.mepc;
         SEL_MCAUSE:                return st.mcause;
         SEL_MTVAL:                 return st.mtval;
         SEL_MCYCLE, SEL_CYCLE:     return st.mcycle_lo;
         SEL_MCYCLEH, SEL_CYCLEH:   return st.mcycle_hi;
         SEL_MINSTRET, SEL_INSTRET: return st.minstret_lo;
         SEL_MINSTRETH, SEL_INSTRETH: return st.minstret_hi;
         default:                   return 32'h0;
      endcase
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with per-half software write.
// A cycle with i_suppress high loads the written halves and keeps the others;
// otherwise the counter advances by i_inc (wrapping at 2^64).
module csr_counter64 #(
   parameter int INC_W = 1          // 1..63
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             i_we_lo,
   input  logic             i_we_hi,
   input  logic [63:0]      i_wdata,
   input  logic [INC_W-1:0] i_inc,
   input  logic             i_suppress,
   output logic [63:0]      o_count
);

   logic [63:0] r_count;

   // Counter state: software write takes priority over the increment.
   // NOTE: asynchronous active-low reset clears state without waiting for a clock edge.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_count <= '0;
      end else if (i_suppress) begin
         r_count <= {i_we_hi ? i_wdata[63:32] : r_count[63:32],
                     i_we_lo ? i_wdata[31:0]  : r_count[31:0]};
      end else begin
         r_count <= r_count + {{(64-INC_W){1'b0}}, i_inc};
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// csr_file: M-mode CSR file with chained CSRRW/CSRRS/CSRRC write ports and
// combinational, fully forwarded read ports.
// Build option: CSR_COUNTERS_EN adds mcycle/minstret (and user aliases);
// without it those addresses are illegal and retire_cnt is ignored.
module csr_file
   import csr_pkg::*;
#(
   parameter int XLEN   = 32,       // only 32 is supported
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2,
   parameter int RET_W  = 2
) (
   input  logic                         clk_in,
   input  logic                         rst_n_in,
   input  logic                         rdy_in,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR-1:0][11:0]      wr_addr,
   input  logic [NUM_WR-1:0][1:0]       wr_op,
   input  logic [NUM_WR-1:0][XLEN-1:0]  wr_data,
   output logic [NUM_WR-1:0]            wr_illegal,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD-1:0][11:0]      rd_addr,
   output logic [NUM_RD-1:0][XLEN-1:0]  rd_data,
   output logic [NUM_RD-1:0]            rd_illegal,
   input  logic [RET_W-1:0]             retire_cnt
);

   logic        w_active;
   logic [63:0] w_mcycle;
   logic [63:0] w_minstret;
   csr_state_t  w_cur;
   csr_state_t  w_final;
   logic        w_cyc_we_lo, w_cyc_we_hi, w_ins_we_lo, w_ins_we_hi;

   logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch;
   logic [31:0] r_mepc, r_mcause, r_mtval;

   // Nothing moves in reset or in a stalled cycle.
   assign w_active = rst_n_in & rdy_in;

   assign w_cur = '{mstatus:     r_mstatus,
                    mie:         r_mie,
                    mtvec:       r_mtvec,
                    mscratch:    r_mscratch,
                    mepc:        r_mepc,
                    mcause:      r_mcause,
                    mtval:       r_mtval,
                    mcycle_lo:   w_mcycle[31:0],
                    mcycle_hi:   w_mcycle[63:32],
                    minstret_lo: w_minstret[31:0],
                    minstret_hi: w_minstret[63:32]};

   // Write chain: port k operates on the state left by ports 0..k-1.
   always_comb begin
      csr_state_t w_st;
      csr_sel_e   w_sel;
      logic       w_req;
      logic [31:0] w_new;
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_st        = w_cur;
      w_cyc_we_lo = 1'b0;
      w_cyc_we_hi = 1'b0;
      w_ins_we_lo = 1'b0;
      w_ins_we_hi = 1'b0;
      wr_illegal  = '0;
      for (int k = 0; k < NUM_WR; k++) begin
         w_sel = csr_decode(wr_addr[k]);
         w_req = w_active & wr_en[k] & (wr_op[k] != OP_NOP);
         wr_illegal[k] = w_req & ~csr_writable(w_sel);
         w_new = csr_rmw(csr_value(w_st, w_sel), wr_op[k], wr_data[k]);
         if (w_req && csr_writable(w_sel)) begin
            case (w_sel)
               SEL_MSTATUS:   w_st.mstatus  = w_new & MSTATUS_MASK;
               SEL_MIE:       w_st.mie      = w_new;
               SEL_MTVEC:     w_st.mtvec    = w_new;
               SEL_MSCRATCH:  w_st.mscratch = w_new;
               SEL_MEPC:      w_st.mepc     = w_new & MEPC_MASK;
               SEL_MCAUSE:    w_st.mcause   = w_new;
               SEL_MTVAL:     w_st.mtval    = w_new;
               SEL_MCYCLE:    begin w_st.mcycle_lo   = w_new; w_cyc_we_lo = 1'b1; end
               SEL_MCYCLEH:   begin w_st.mcycle_hi   = w_new; w_cyc_we_hi = 1'b1; end
               SEL_MINSTRET:  begin w_st.minstret_lo = w_new; w_ins_we_lo = 1'b1; end
               SEL_MINSTRETH: begin w_st.minstret_hi = w_new; w_ins_we_hi = 1'b1; end
               default:       ;
            endcase
         end
      end
      w_final = w_st;
   end

   // Trap CSRs take the end-of-chain value each edge.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_mstatus  <= '0;
         r_mie      <= '0;
         r_mtvec    <= '0;
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         r_mstatus  <= w_final.mstatus;
         r_mie      <= w_final.mie;
         r_mtvec    <= w_final.mtvec;
         r_mscratch <= w_final.mscratch;
         r_mepc     <= w_final.mepc;
         r_mcause   <= w_final.mcause;
         r_mtval    <= w_final.mtval;
      end
   end

`ifdef CSR_COUNTERS_EN
   logic [RET_W-1:0] w_retire;
   assign w_retire = w_active ? retire_cnt : '0;

   csr_counter64 #(.INC_W(1)) u_mcycle (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .i_we_lo    (w_cyc_we_lo),
      .i_we_hi    (w_cyc_we_hi),
      .i_wdata    ({w_final.mcycle_hi, w_final.mcycle_lo}),
      .i_inc      (w_active),
      .i_suppress (w_cyc_we_lo | w_cyc_we_hi),
      .o_count    (w_mcycle)
   );

   csr_counter64 #(.INC_W(RET_W)) u_minstret (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .i_we_lo    (w_ins_we_lo),
      .i_we_hi    (w_ins_we_hi),
      .i_wdata    ({w_final.minstret_hi, w_final.minstret_lo}),
      .i_inc      (w_retire),
      .i_suppress (w_ins_we_lo | w_ins_we_hi),
      .o_count    (w_minstret)
   );
`else
   logic w_unused_counters;
   assign w_mcycle   = '0;
   assign w_minstret = '0;
   assign w_unused_counters = ^{retire_cnt, w_cyc_we_lo, w_cyc_we_hi, w_ins_we_lo,
                                w_ins_we_hi, w_final.mcycle_lo, w_final.mcycle_hi,
                                w_final.minstret_lo, w_final.minstret_hi};
`endif

   // Read ports: decode, forward from the end of the write chain, gate by rdy/enable.
   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      always_comb begin
         csr_sel_e w_sel;
         w_sel = csr_decode(rd_addr[r]);
         rd_illegal[r] = w_active & rd_en[r] & (w_sel == SEL_NONE);
         rd_data[r]    = (rdy_in && rd_en[r] && (w_sel != SEL_NONE))
                         ? csr_value(w_final, w_sel) : '0;
      end
   end

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed self-checking bench for csr_file.
// Counter scenarios run when CSR_COUNTERS_EN is defined; otherwise the
// counter addresses are checked as illegal.
module tb_csr_file;
   import csr_pkg::*;

   localparam int XLEN = 32, NUM_RD = 2, NUM_WR = 2, RET_W = 2;

   logic                        clk_in = 1'b0;
   logic                        rst_n_in;
   logic                        rdy_in;
   logic [NUM_WR-1:0]           wr_en;
   logic [NUM_WR-1:0][11:0]     wr_addr;
   logic [NUM_WR-1:0][1:0]      wr_op;
   logic [NUM_WR-1:0][XLEN-1:0] wr_data;
   logic [NUM_WR-1:0]           wr_illegal;
   logic [NUM_RD-1:0]           rd_en;
   logic [NUM_RD-1:0][11:0]     rd_addr;
   logic [NUM_RD-1:0][XLEN-1:0] rd_data;
   logic [NUM_RD-1:0]           rd_illegal;
   logic [RET_W-1:0]            retire_cnt;

   int tests = 0;
   int fails = 0;

   csr_file #(.XLEN(XLEN), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .RET_W(RET_W)) dut (
      .clk_in     (clk_in),
      .rst_n_in   (rst_n_in),
      .rdy_in     (rdy_in),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_op      (wr_op),
      .wr_data    (wr_data),
      .wr_illegal (wr_illegal),
      .rd_en      (rd_en),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_illegal (rd_illegal),
      .retire_cnt (retire_cnt)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clr();
      wr_en   = '0;
      wr_addr = '0;
      wr_op   = '0;
      wr_data = '0;
      rd_en   = '0;
      rd_addr = '0;
   endtask

   task automatic wr(input int p, input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
      wr_en[p]   = 1'b1;
      wr_addr[p] = a;
      wr_op[p]   = op;
      wr_data[p] = d;
   endtask

   task automatic rd(input int p, input logic [11:0] a);
      rd_en[p]   = 1'b1;
      rd_addr[p] = a;
   endtask

   initial begin
      rst_n_in   = 1'b0;
      rdy_in     = 1'b1;
      retire_cnt = '0;
      clr();

      // Reset state while reset is held.
      rd(0, CSR_MISA); rd(1, 12'h7C0); #1;
      check("rst_misa", rd_data[0], 32'h4000_0100);
      check("rst_rd_illegal_gated", rd_illegal, 2'b00);
      rd(0, CSR_MSCRATCH); #1;
      check("rst_mscratch", rd_data[0], 32'h0);
      tick(); tick();
      rst_n_in = 1'b1;
      clr();

`ifdef CSR_COUNTERS_EN
      // First cycle after release counts to 1 at the next edge.
      rd(0, CSR_MCYCLE); #1;
      check("mcycle_after_release", rd_data[0], 32'h0);
      tick();
      check("mcycle_first_edge", rd_data[0], 32'h1);
      clr();
`endif

      // Reset values after release.
      rd(0, CSR_MISA); rd(1, 12'h7C0); #1;
      check("misa_value", rd_data[0], 32'h4000_0100);
      check("rd_illegal_7c0", rd_illegal, 2'b10);
      check("rd_illegal_data0", rd_data[1], 32'h0);
      rd(0, CSR_MSCRATCH); #1;
      check("mscratch_reset", rd_data[0], 32'h0);

      // Write chain on one CSR: RW then RS in one cycle.
      wr(0, CSR_MSCRATCH, OP_RW, 32'h0000_00F0);
      wr(1, CSR_MSCRATCH, OP_RS, 32'h0000_000F); #1;
      check("chain_rw_rs_fwd", rd_data[0], 32'hFF);
      tick(); clr(); rd(0, CSR_MSCRATCH); #1;
      check("chain_rw_rs_hold", rd_data[0], 32'hFF);
      wr(0, CSR_MSCRATCH, OP_RC, 32'hF0); #1;
      check("rc_fwd", rd_data[0], 32'h0F);
      tick(); clr(); rd(0, CSR_MSCRATCH); #1;
      check("rc_hold", rd_data[0], 32'h0F);
      wr(0, CSR_MSCRATCH, OP_RS, 32'hF00);
      wr(1, CSR_MSCRATCH, OP_RC, 32'h00F); #1;
      check("chain_rs_rc_fwd", rd_data[0], 32'hF00);
      tick(); clr();

      // Illegal writes: read-only alias / misa; a no-op to misa is fine.
      wr(0, CSR_CYCLE, OP_RW, 32'h1234);
      wr(1, CSR_MISA, OP_RS, 32'h1); #1;
      check("wr_illegal_ro", wr_illegal, 2'b11);
      clr();
      wr(0, CSR_MISA, OP_NOP, 32'hFFFF_FFFF);
      wr(1, 12'h7C0, OP_RW, 32'h1); #1;
      check("wr_illegal_nop_unimpl", wr_illegal, 2'b10);
      tick(); clr();

      // mstatus keeps only MIE/MPIE.
      wr(0, CSR_MSTATUS, OP_RW, 32'hFFFF_FFFF);
      tick(); clr(); rd(0, CSR_MSTATUS); #1;
      check("mstatus_mask", rd_data[0], 32'h88);
      wr(1, CSR_MSTATUS, OP_RC, 32'h08); #1;
      check("mstatus_rc_fwd", rd_data[0], 32'h80);
      tick(); clr();

      // mepc low bits read 0; mip is read-only zero.
      wr(0, CSR_MEPC, OP_RW, 32'h0000_1237);
      rd(0, CSR_MEPC); rd(1, CSR_MIP); #1;
      check("mepc_fwd", rd_data[0], 32'h1234);
      check("mip_zero", rd_data[1], 32'h0);
      tick(); clr(); rd(0, CSR_MEPC); #1;
      check("mepc_hold", rd_data[0], 32'h1234);
      wr(1, CSR_MIP, OP_RW, 32'h5); #1;
      check("mip_wr_illegal", wr_illegal, 2'b10);
      tick(); clr();

      // Stall: nothing changes and every read returns 0.
      rdy_in = 1'b0;
      wr(0, CSR_MSCRATCH, OP_RW, 32'hDEAD);
      wr(1, CSR_CYCLE, OP_RW, 32'h1);
      rd(0, CSR_MSCRATCH); rd(1, 12'h7C0); #1;
      check("stall_rd_zero", rd_data[0], 32'h0);
      check("stall_wr_illegal", wr_illegal, 2'b00);
      check("stall_rd_illegal", rd_illegal, 2'b00);
      rd(1, CSR_MISA); #1;
      check("stall_misa_zero", rd_data[1], 32'h0);
      tick(); tick(); tick();
      rdy_in = 1'b1;
      clr(); rd(0, CSR_MSCRATCH); #1;
      check("stall_resume", rd_data[0], 32'hF00);

`ifdef CSR_COUNTERS_EN
      // 64-bit carry: FFFF_FFFE + 3 -> 1_0000_0001.
      clr();
      wr(0, CSR_MCYCLE, OP_RW, 32'hFFFF_FFFE);
      wr(1, CSR_MCYCLEH, OP_RW, 32'h0);
      rd(0, CSR_MCYCLE); #1;
      check("mcycle_wr_fwd", rd_data[0], 32'hFFFF_FFFE);
      tick(); clr(); rd(0, CSR_MCYCLE); rd(1, CSR_MCYCLEH); #1;
      check("mcycle_wr_no_inc", rd_data[0], 32'hFFFF_FFFE);
      check("mcycleh_wr", rd_data[1], 32'h0);
      wr(0, CSR_CYCLE, OP_RW, 32'h5); #1;
      check("cycle_alias_illegal", wr_illegal, 2'b01);
      tick(); clr(); tick(); tick();
      rd(0, CSR_MCYCLE); rd(1, CSR_MCYCLEH); #1;
      check("mcycle_carry_lo", rd_data[0], 32'h1);
      check("mcycle_carry_hi", rd_data[1], 32'h1);
      rd(0, CSR_CYCLE); rd(1, CSR_CYCLEH); #1;
      check("cycle_alias_lo", rd_data[0], 32'h1);
      check("cycle_alias_hi", rd_data[1], 32'h1);
      rdy_in = 1'b0;
      repeat (5) tick();
      rdy_in = 1'b1;
      rd(0, CSR_MCYCLE); rd(1, CSR_MCYCLEH); #1;
      check("mcycle_frozen_lo", rd_data[0], 32'h1);
      check("mcycle_frozen_hi", rd_data[1], 32'h1);

      // minstret: 4 x 2 retires, then a write wins over retire_cnt=3.
      clr();
      wr(0, CSR_MINSTRET, OP_RW, 32'h0);
      wr(1, CSR_MINSTRETH, OP_RW, 32'h0);
      tick(); clr();
      retire_cnt = 2'd2;
      repeat (4) tick();
      retire_cnt = 2'd0;
      rd(0, CSR_MINSTRET); rd(1, CSR_INSTRET); #1;
      check("minstret_8", rd_data[0], 32'h8);
      check("instret_alias_8", rd_data[1], 32'h8);
      clr();
      retire_cnt = 2'd3;
      wr(0, CSR_MINSTRET, OP_RW, 32'h100);
      tick(); clr();
      retire_cnt = 2'd0;
      rd(0, CSR_MINSTRET); rd(1, CSR_MINSTRETH); #1;
      check("minstret_write_wins", rd_data[0], 32'h100);
      check("minstreth_held", rd_data[1], 32'h0);
`else
      // Counters compiled out: their addresses are illegal.
      clr();
      rd(0, CSR_MCYCLE); rd(1, CSR_INSTRETH); #1;
      check("ctr_rd_illegal", rd_illegal, 2'b11);
      check("ctr_rd_data0", rd_data[0], 32'h0);
      wr(0, CSR_MINSTRET, OP_RW, 32'h5); #1;
      check("ctr_wr_illegal", wr_illegal, 2'b01);
      tick();
`endif

      // Async reset in the middle of a write clears the target at once.
      clr();
      wr(0, CSR_MSCRATCH, OP_RW, 32'h55);
      rd(0, CSR_MSCRATCH); rd(1, CSR_MSTATUS); #1;
      check("pre_reset_fwd", rd_data[0], 32'h55);
      #2;
      rst_n_in = 1'b0;
      #1;
      check("async_rst_mscratch", rd_data[0], 32'h0);
      check("async_rst_mstatus", rd_data[1], 32'h0);
      tick();
      clr();
      rst_n_in = 1'b1;
      rd(0, CSR_MSCRATCH); rd(1, CSR_MEPC); #1;
      check("post_rst_mscratch", rd_data[0], 32'h0);
      check("post_rst_mepc", rd_data[1], 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
